rom_loader: RTL and testbench
=============================

# rom_loader

Download front end between the HPS ioctl interface and the williams2 core's ROM stores. It accepts the byte stream pushed by hps_io during a ROM download, decodes the linear download address into the CPU program, sound and graphics ROM regions, and issues one region-local write per byte to the target store, back-pressuring hps_io through `ioctl_wait` while a write is pending. It also holds the core in reset for the whole download and reports the byte count, a 16-bit checksum and error flags.

## Interface
Parameters:
- `ROM_INDEX`, 8'd0: the `ioctl_index` value that selects ROM downloads; all other indices are ignored.
- `BASE1`, 17'h0C000: first byte of the sound region, which is also the end of the program region.
- `BASE2`, 17'h10000: first byte of the graphics region.
- `BASE3`, 17'h1C000: end of the graphics region; bytes at or above this address are out of range.
- `HOLD_CYCLES`, 16: number of cycles `core_reset` stays high after the download ends.

Ports:
- `clk_sys`, in, 1: system clock (12 MHz).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ioctl_download`, in, 1: a download is in progress.
- `ioctl_index`, in, 8: download index.
- `ioctl_wr`, in, 1: one-cycle byte strobe.
- `ioctl_addr`, in, 17: linear byte address.
- `ioctl_dout`, in, 8: byte data.
- `ioctl_wait`, out, 1: stall request to hps_io.
- `rom_we`, out, 1: write request to the ROM store.
- `rom_sel`, out, 2: target region; 0 = program, 1 = sound, 2 = graphics.
- `rom_addr`, out, 17: region-local address, i.e. `ioctl_addr` minus the region base.
- `rom_data`, out, 8: write data.
- `rom_busy`, in, 1: the ROM store cannot accept a write this cycle.
- `core_reset`, out, 1: active-high reset to williams2.
- `dl_done`, out, 1: sticky; at least one download has completed since reset.
- `byte_count`, out, 18: number of in-range bytes written in the current or last download.
- `checksum`, out, 16: modulo-2^16 sum of those bytes.
- `err_overflow`, out, 1: sticky; a byte addressed at or above `BASE3` was received.
- `err_protocol`, out, 1: sticky; `ioctl_wr` arrived while a write was still pending.

## Operation
- The state machine has four states: IDLE, LOAD, WRITE and HOLD. Reset state is IDLE.
- An active download means `ioctl_download` is high and `ioctl_index` equals `ROM_INDEX`.
- IDLE → LOAD when an active download is seen. On this transition, clear `byte_count` and `checksum`.
- In LOAD, `ioctl_wr` is handled by address:
  - In-range address: latch the mapped address, region and data, set `ioctl_wait`, and go to WRITE.
  - Address at or above `BASE3`: set `err_overflow` and stay in LOAD. No write is issued.
- In WRITE, `rom_we` is high. The write is accepted on a rising edge where `rom_busy` is low. On acceptance:
  - increment `byte_count`;
  - add `rom_data` (zero-extended) to `checksum`;
  - clear `ioctl_wait`;
  - go to LOAD, or to HOLD if the download has already ended.
- An `ioctl_wr` received in WRITE is dropped and sets `err_protocol`. The pending write is not disturbed.
- LOAD → HOLD when the download goes inactive. The HOLD counter is loaded with `HOLD_CYCLES`.
- In HOLD, the counter decrements each cycle. HOLD → IDLE when the counter reaches 0; `dl_done` is set on that edge.
- A new active download seen in HOLD goes to LOAD. `byte_count` and `checksum` are cleared, and `dl_done` is left unchanged.
- `core_reset` is high whenever the state is not IDLE, and also from reset until the first IDLE cycle after reset.
- Region decode compares the address unsigned: `addr < BASE1` → 0; `addr < BASE2` → 1; `addr < BASE3` → 2.
- `ioctl_index` and `ioctl_download` are sampled every cycle. An index change in the middle of a download is treated as the download ending.

## Timing
- Every output is registered.
- Reset values: all outputs 0, except `core_reset`, which is 1.
- Unloaded latency: `ioctl_wr` in cycle t → `rom_we` and `ioctl_wait` high in cycle t+1. With `rom_busy` low, the write is accepted at the end of t+1, so `rom_we` and `ioctl_wait` are low in t+2.
- If `rom_busy` stays high for N cycles, `rom_we` and `ioctl_wait` stay high for N+1 cycles. `rom_addr`, `rom_sel` and `rom_data` remain stable throughout.
- Minimum spacing between accepted bytes is 2 cycles.
- Simultaneous events:
  - Download falling in the same cycle as an `ioctl_wr` in LOAD: the byte is written, then the machine goes to HOLD.
  - Download falling while in WRITE: the pending write completes first.
- `byte_count` saturates at 2^18−1.
- `reset_n` asserted at any point forces reset values asynchronously. Any pending write is abandoned.

## Structure
- A shared package `rom_loader_pkg` holds:
  - the state enum;
  - the region-code constants `REG_PROG`, `REG_SND`, `REG_GFX`;
  - the default base addresses.
- One sub-module, `rom_region_decode`: a combinational block that maps `ioctl_addr` to region, local address and an out-of-range flag. It is reused by the upload path.

## Test plan
- Write 3 bytes at 0x00000, 0x0C000 and 0x10005 with `rom_busy` = 0:
  - expect `rom_sel` 0/1/2 and `rom_addr` 0x00000/0x00000/0x00005;
  - expect each `rom_we` and `ioctl_wait` to last exactly 1 cycle;
  - expect `byte_count` = 3 and `checksum` = the sum of the bytes.
- Hold `rom_busy` high for 5 cycles on a write of 0xA5 to 0x00010: expect `ioctl_wait` and `rom_we` high for 6 cycles with address and data stable, and exactly one write accepted.
- Write to 0x1C000: expect no `rom_we`, `err_overflow` = 1, and `byte_count` unchanged.
- Pulse `ioctl_wr` again while `rom_busy` holds a write pending: expect `err_protocol` = 1, the original data written, and the second byte dropped.
- Drop `ioctl_download` after the last byte: expect `core_reset` to fall exactly `HOLD_CYCLES` + 1 cycles later, and `dl_done` to go high on that same edge.
- Download with `ioctl_index` = 1: expect no writes and `core_reset` low. Separately, assert `reset_n` low mid-WRITE: expect `rom_we` = 0 and `core_reset` = 1 immediately.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the williams2 ROM download front end.
package rom_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] REG_PROG = 2'd0;
  localparam logic [1:0] REG_SND  = 2'd1;
  localparam logic [1:0] REG_GFX  = 2'd2;

  localparam logic [16:0] DEF_BASE1 = 17'h0C000;
  localparam logic [16:0] DEF_BASE2 = 17'h10000;
  localparam logic [16:0] DEF_BASE3 = 17'h1C000;

  function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
    return sum + {8'h00, b};
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Maps a linear download address onto a ROM region and region-local address.
module rom_region_decode
  import rom_loader_pkg::*;
#(
  parameter logic [16:0] BASE1 = DEF_BASE1,
  parameter logic [16:0] BASE2 = DEF_BASE2,
  parameter logic [16:0] BASE3 = DEF_BASE3
) (
  input  logic [16:0] addr,
  output logic [1:0]  region,
  output logic [16:0] local_addr,
  output logic        out_of_range
);

  // Unsigned range compare against the region bases
  always_comb begin
    region       = REG_PROG;
    local_addr   = addr;
    out_of_range = 1'b0;
    if (addr < BASE1) begin
      region     = REG_PROG;
      local_addr = addr;
    end else if (addr < BASE2) begin
      region     = REG_SND;
      local_addr = addr - BASE1;
    end else if (addr < BASE3) begin
      region     = REG_GFX;
      local_addr = addr - BASE2;
    end else begin
      local_addr   = 17'h00000;
      out_of_range = 1'b1;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// ROM download front end: ioctl byte stream to region-local ROM writes,
// with core reset hold, byte count, checksum and error flags.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [16:0] BASE1       = DEF_BASE1,
  parameter logic [16:0] BASE2       = DEF_BASE2,
  parameter logic [16:0] BASE3       = DEF_BASE3,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_we,
  output logic [1:0]  rom_sel,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  input  logic        rom_busy,
  output logic        core_reset,
  output logic        dl_done,
  output logic [17:0] byte_count,
  output logic [15:0] checksum,
  output logic        err_overflow,
  output logic        err_protocol
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES);

  state_t      state_r, next_s;
  logic [15:0] hold_cnt_r;
  logic        end_seen_r;
  logic        active_s, accept_s, start_s, latch_s;
  logic [1:0]  region_s;
  logic [16:0] local_addr_s;
  logic        oor_s;

  logic        ioctl_wait_r, rom_we_r, core_reset_r, dl_done_r;
  logic        err_overflow_r, err_protocol_r;
  logic [1:0]  rom_sel_r;
  logic [16:0] rom_addr_r;
  logic [7:0]  rom_data_r;
  logic [17:0] byte_count_r;
  logic [15:0] checksum_r;

  rom_region_decode #(
    .BASE1 (BASE1),
    .BASE2 (BASE2),
    .BASE3 (BASE3)
  ) u_decode (
    .addr         (ioctl_addr),
    .region       (region_s),
    .local_addr   (local_addr_s),
    .out_of_range (oor_s)
  );

  assign active_s = ioctl_download && (ioctl_index == ROM_INDEX);
  assign accept_s = (state_r == ST_WRITE) && !rom_busy;
  assign start_s  = ((state_r == ST_IDLE) || (state_r == ST_HOLD)) && active_s;
  assign latch_s  = (state_r == ST_LOAD) && ioctl_wr && !oor_s;

  // Next-state decode; a byte strobe in LOAD wins over the download ending
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (active_s) next_s = ST_LOAD;
        else          next_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (ioctl_wr && !oor_s) next_s = ST_WRITE;
        else if (!active_s)     next_s = ST_HOLD;
        else                    next_s = ST_LOAD;
      end
      ST_WRITE: begin
        if (rom_busy)                      next_s = ST_WRITE;
        else if (end_seen_r || !active_s)  next_s = ST_HOLD;
        else                               next_s = ST_LOAD;
      end
      ST_HOLD: begin
        if (active_s)                  next_s = ST_LOAD;
        else if (hold_cnt_r == 16'd0)  next_s = ST_IDLE;
        else                           next_s = ST_HOLD;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // State, hold counter and handshake outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= 16'd0;
      end_seen_r   <= 1'b0;
      rom_we_r     <= 1'b0;
      ioctl_wait_r <= 1'b0;
      core_reset_r <= 1'b1;
      dl_done_r    <= 1'b0;
    end else begin
      state_r      <= next_s;
      rom_we_r     <= (next_s == ST_WRITE);
      ioctl_wait_r <= (next_s == ST_WRITE);
      core_reset_r <= (next_s != ST_IDLE);
      if ((next_s == ST_HOLD) && (state_r != ST_HOLD))
        hold_cnt_r <= HOLD_LOAD;
      else if ((state_r == ST_HOLD) && (hold_cnt_r != 16'd0))
        hold_cnt_r <= hold_cnt_r - 16'd1;
      // Remembers a download end seen while a write is still outstanding
      if (start_s)
        end_seen_r <= 1'b0;
      else if (((state_r == ST_LOAD) || (state_r == ST_WRITE)) && !active_s)
        end_seen_r <= 1'b1;
      if ((state_r == ST_HOLD) && (next_s == ST_IDLE))
        dl_done_r <= 1'b1;
    end
  end

  // Write latch, statistics and sticky error flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_sel_r      <= REG_PROG;
      rom_addr_r     <= 17'h00000;
      rom_data_r     <= 8'h00;
      byte_count_r   <= 18'd0;
      checksum_r     <= 16'h0000;
      err_overflow_r <= 1'b0;
      err_protocol_r <= 1'b0;
    end else begin
      if (latch_s) begin
        rom_sel_r  <= region_s;
        rom_addr_r <= local_addr_s;
        rom_data_r <= ioctl_dout;
      end
      if (start_s) begin
        byte_count_r <= 18'd0;
        checksum_r   <= 16'h0000;
      end else if (accept_s) begin
        if (byte_count_r != 18'h3FFFF) byte_count_r <= byte_count_r + 18'd1;
        checksum_r <= csum_add(checksum_r, rom_data_r);
      end
      if ((state_r == ST_LOAD) && ioctl_wr && oor_s) err_overflow_r <= 1'b1;
      if ((state_r == ST_WRITE) && ioctl_wr)         err_protocol_r <= 1'b1;
    end
  end

  assign ioctl_wait   = ioctl_wait_r;
  assign rom_we       = rom_we_r;
  assign rom_sel      = rom_sel_r;
  assign rom_addr     = rom_addr_r;
  assign rom_data     = rom_data_r;
  assign core_reset   = core_reset_r;
  assign dl_done      = dl_done_r;
  assign byte_count   = byte_count_r;
  assign checksum     = checksum_r;
  assign err_overflow = err_overflow_r;
  assign err_protocol = err_protocol_r;

endmodule

// File: tb/tb_rom_loader.sv
// Directed, table-driven bench for rom_loader with hand-computed expectations.
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_we;
  logic [1:0]  rom_sel;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_busy;
  logic        core_reset;
  logic        dl_done;
  logic [17:0] byte_count;
  logic [15:0] checksum;
  logic        err_overflow;
  logic        err_protocol;

  int n_cmp = 0;
  int n_bad = 0;

  rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .rom_we         (rom_we),
    .rom_sel        (rom_sel),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_busy       (rom_busy),
    .core_reset     (core_reset),
    .dl_done        (dl_done),
    .byte_count     (byte_count),
    .checksum       (checksum),
    .err_overflow   (err_overflow),
    .err_protocol   (err_protocol)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [1:0]  exp_sel;
    logic [16:0] exp_addr;
    logic [17:0] exp_count;
    logic [15:0] exp_csum;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    vecs[0] = '{17'h00000, 8'h12, 2'd0, 17'h00000, 18'd1, 16'h0012};
    vecs[1] = '{17'h0C000, 8'h34, 2'd1, 17'h00000, 18'd2, 16'h0046};
    vecs[2] = '{17'h10005, 8'h56, 2'd2, 17'h00005, 18'd3, 16'h009C};
    vecs[3] = '{17'h1BFFF, 8'hFF, 2'd2, 17'h0BFFF, 18'd4, 16'h019B};
    vecs[4] = '{17'h0BFFF, 8'h80, 2'd0, 17'h0BFFF, 18'd5, 16'h021B};
    vecs[5] = '{17'h0FFFF, 8'h01, 2'd1, 17'h03FFF, 18'd6, 16'h021C};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 17'h0; ioctl_dout = 8'h0; rom_busy = 1'b0;
    tick(); tick();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_dl_done", 32'(dl_done), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_errs", 32'({err_overflow, err_protocol}), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_core_reset", 32'(core_reset), 32'd0);

    ioctl_download = 1'b1;
    tick();
    chk("load_core_reset", 32'(core_reset), 32'd1);

    for (int i = 0; i < 6; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = vecs[i].addr; ioctl_dout = vecs[i].data;
      tick();
      ioctl_wr = 1'b0;
      chk($sformatf("v%0d_we", i), 32'(rom_we), 32'd1);
      chk($sformatf("v%0d_wait", i), 32'(ioctl_wait), 32'd1);
      chk($sformatf("v%0d_sel", i), 32'(rom_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_data", i), 32'(rom_data), 32'(vecs[i].data));
      tick();
      chk($sformatf("v%0d_we_off", i), 32'({rom_we, ioctl_wait}), 32'd0);
      chk($sformatf("v%0d_count", i), 32'(byte_count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d_csum", i), 32'(checksum), 32'(vecs[i].exp_csum));
    end

    // Back-pressure: busy for 5 cycles stretches the write to 6
    ioctl_wr = 1'b1; ioctl_addr = 17'h00010; ioctl_dout = 8'hA5;
    tick();
    ioctl_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rom_busy = (i < 5);
      chk($sformatf("busy%0d_we_wait", i), 32'({rom_we, ioctl_wait}), 32'd3);
      chk($sformatf("busy%0d_addr", i), 32'(rom_addr), 32'h10);
      chk($sformatf("busy%0d_data", i), 32'(rom_data), 32'hA5);
      tick();
    end
    chk("busy_we_off", 32'({rom_we, ioctl_wait}), 32'd0);
    chk("busy_count", 32'(byte_count), 32'd7);
    chk("busy_csum", 32'(checksum), 32'h02C1);

    // Out-of-range byte
    ioctl_wr = 1'b1; ioctl_addr = 17'h1C000; ioctl_dout = 8'h77;
    tick();
    ioctl_wr = 1'b0;
    chk("ovf_we", 32'(rom_we), 32'd0);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    tick();
    chk("ovf_count", 32'(byte_count), 32'd7);

    // Second strobe while a write is pending
    rom_busy = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 17'h00020; ioctl_dout = 8'h3C;
    tick();
    ioctl_wr = 1'b0;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 17'h00030; ioctl_dout = 8'hC3;
    tick();
    ioctl_wr = 1'b0; rom_busy = 1'b0;
    chk("proto_flag", 32'(err_protocol), 32'd1);
    chk("proto_addr", 32'(rom_addr), 32'h20);
    chk("proto_data", 32'(rom_data), 32'h3C);
    tick();
    chk("proto_count", 32'(byte_count), 32'd8);
    chk("proto_csum", 32'(checksum), 32'h02FD);
    tick();
    chk("proto_dropped_we", 32'(rom_we), 32'd0);
    chk("proto_dropped_count", 32'(byte_count), 32'd8);

    // Download falls together with the last byte, then the reset hold
    ioctl_download = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 17'h00040; ioctl_dout = 8'h01;
    tick();
    ioctl_wr = 1'b0;
    chk("last_we", 32'(rom_we), 32'd1);
    tick();
    chk("last_count", 32'(byte_count), 32'd9);
    chk("last_csum", 32'(checksum), 32'h02FE);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("hold%0d_core_reset", i), 32'({core_reset, dl_done}), 32'd2);
    end
    tick();
    chk("hold_end", 32'({core_reset, dl_done}), 32'd1);

    // Foreign index is ignored
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 17'h00000; ioctl_dout = 8'h55;
    for (int i = 0; i < 4; i++) begin
      tick();
      ioctl_wr = 1'b0;
      chk($sformatf("idx1_%0d", i), 32'({rom_we, core_reset}), 32'd0);
    end
    chk("idx1_count", 32'(byte_count), 32'd9);

    // New download clears statistics, keeps dl_done
    ioctl_index = 8'd0;
    tick();
    chk("restart_count", 32'(byte_count), 32'd0);
    chk("restart_csum", 32'(checksum), 32'd0);
    chk("restart_flags", 32'({core_reset, dl_done}), 32'd3);

    // Asynchronous reset in the middle of a pending write
    rom_busy = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 17'h00005; ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    chk("pre_rst_we", 32'(rom_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_we_wait", 32'({rom_we, ioctl_wait}), 32'd0);
    chk("async_rst_core_reset", 32'(core_reset), 32'd1);
    chk("async_rst_dl_done", 32'(dl_done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
